alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU. Accepts one operation per transfer over a valid/ready interface. Single-cycle ops are registered with one cycle of latency; MUL is an iterative shift-add that takes WIDTH cycles. Returns the result with zero, negative, carry and overflow flags plus an illegal-opcode flag. Sits between the decode/register-read stage and writeback, and can stall either side.

## Interface
- WIDTH, 16: operand and result width, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount bits (derived, not overridden).

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- alu_ctrl  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- carry  out  1  ADD carry-out; SUB borrow (a < b unsigned); 0 otherwise
- ovf  out  1  ADD/SUB signed overflow; MUL: upper half of 2·WIDTH product nonzero; 0 otherwise
- err  out  1  illegal opcode

## Operation
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 NOT a; 0011 SHL; 0100 SHR (logical); 0101 AND; 0110 OR.
  - 0111 SLTU (unsigned a<b → 1, else 0); 1000 XOR; 1001 SRA; 1010 SLT (signed); 1011 MUL (unsigned, low WIDTH bits).
  - 1100–1111 illegal: result 0, err=1, other flags from result (zero=1).
- Shifts use the full b as the shift amount.
  - b ≥ WIDTH: SHL/SHR give 0; SRA gives all copies of a[WIDTH-1].
  - b == 0: result is a.
- A transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput while the consumer keeps out_ready high.
- FSM:
  - IDLE: accept.
    - Non-MUL: result and flags are written to the output register, out_valid=1 next cycle, stay in IDLE.
    - MUL: latch a and b, clear accumulator, cnt=0, go to MULT.
  - MULT: each cycle, if b_sh[0], acc += a_sh (2·WIDTH bits); then a_sh<<=1, b_sh>>=1, cnt++. in_ready=0.
    - When cnt==WIDTH-1, the final iteration writes result=acc[WIDTH-1:0] and ovf=|acc[2W-1:W], sets out_valid, and returns to IDLE.
- The output register holds result and flags stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result loads in the same cycle.
- Flags are computed from the registered result. neg and zero are valid for every opcode.

## Timing
- Reset (rst=1 at clk edge): state=IDLE, out_valid=0, result=0, zero=0, neg=0, carry=0, ovf=0, err=0, cnt=0. in_ready=1 from the first cycle after reset. Reset during MULT aborts the operation and no result is produced.
- Single-cycle op latency: accept at edge N → out_valid=1 after edge N+1.
- MUL latency: accept at edge N → out_valid=1 after edge N+WIDTH. in_ready=0 for those WIDTH cycles.
- Back-pressure: if out_valid && !out_ready, in_ready=0 and nothing is accepted. Inputs presented during this time must be held by the producer.
- Simultaneous out_ready and new accept: old result retires, new result loads, and out_valid stays 1.
- in_valid while in_ready=0 is ignored. The producer must hold a, b and alu_ctrl stable until in_ready.
- Arithmetic is WIDTH bits, wrap-around; carry and ovf report the wrap.

## Test plan
- Reset then ADD a=16'hFFFF, b=1, out_ready=1 → one cycle later: result=0, zero=1, carry=1, ovf=0. SUB a=16'h8000, b=1 → result=16'h7FFF, ovf=1, carry=0.
- Shifts with WIDTH=16, a=16'h8001:
  - SHL b=4 → 16'h0010.
  - SHR b=16 → 0.
  - SRA b=3 → 16'hF000.
  - SRA b=40 → 16'hFFFF.
- SLTU vs SLT with a=16'hFFFF, b=1 → SLTU gives 0; SLT gives 1.
- MUL a=300, b=300 → out_valid exactly 16 cycles after accept, result=16'h5F90, ovf=1, in_ready=0 throughout. MUL a=7, b=9 → 63, ovf=0.
- Back-pressure: issue 3 ADDs with out_ready held 0 → only the first is accepted, result held stable. Raise out_ready → remaining ops accepted one per cycle, results appear in order.
- Opcode 4'b1110 → result=0, err=1, zero=1. Assert rst mid-MUL at cnt=5 → next cycle out_valid=0, in_ready=1, and no stale result appears later.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered output stage and an iterative
// shift-add multiplier. Single-cycle ops return one cycle after acceptance,
// MUL returns WIDTH cycles after acceptance. The output register holds its
// contents under back-pressure.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new operation (subject to output back-pressure)
// MULT  | shift-add multiply in progress, r_cnt counts iterations
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MULT = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam logic [WIDTH-1:0] LP_SH_MAX   = WIDTH'(WIDTH - 1);
  localparam logic [SHW-1:0]   LP_CNT_LAST = SHW'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [2*WIDTH-1:0] r_acc;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_neg;
  logic               r_carry;
  logic               r_ovf;
  logic               r_err;

  logic               w_accept;
  logic               w_load_alu;
  logic               w_load_mul;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_sh_big;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_sra;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic               w_alu_ovf;
  logic               w_alu_err;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_ld_res;
  logic               w_ld_carry;
  logic               w_ld_ovf;
  logic               w_ld_err;

  assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_load_alu = w_accept && (alu_ctrl != OP_MUL);
  assign w_load_mul = (r_state == S_MULT) && (r_cnt == LP_CNT_LAST);

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};
  // Any shift amount past WIDTH-1 saturates; below that the low bits suffice.
  assign w_sh_big = (b > LP_SH_MAX);
  assign w_shamt  = b[SHW-1:0];
  assign w_sra    = $signed(a) >>> w_shamt;

  // Multiplier step: conditionally add the shifted multiplicand.
  assign w_acc_nxt = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

  // Single-cycle ALU: result plus carry/overflow/illegal indications.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    w_alu_err   = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
        w_alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  w_alu_res = ~a;
      OP_SHL:  w_alu_res = w_sh_big ? '0 : (a << w_shamt);
      OP_SHR:  w_alu_res = w_sh_big ? '0 : (a >> w_shamt);
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  w_alu_res = a ^ b;
      OP_SRA:  w_alu_res = w_sh_big ? {WIDTH{a[WIDTH-1]}} : w_sra;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL:  w_alu_res = '0;
      default: w_alu_err = 1'b1;
    endcase
  end

  // Select what the output register loads: multiplier completion or ALU.
  always_comb begin
    w_ld_res   = w_alu_res;
    w_ld_carry = w_alu_carry;
    w_ld_ovf   = w_alu_ovf;
    w_ld_err   = w_alu_err;
    if (w_load_mul) begin
      w_ld_res   = w_acc_nxt[WIDTH-1:0];
      w_ld_carry = 1'b0;
      w_ld_ovf   = |w_acc_nxt[2*WIDTH-1:WIDTH];
      w_ld_err   = 1'b0;
    end
  end

  // Control FSM and multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (alu_ctrl == OP_MUL)) begin
            r_state <= S_MULT;
            r_cnt   <= '0;
            r_a_sh  <= {{WIDTH{1'b0}}, a};
            r_b_sh  <= b;
            r_acc   <= '0;
          end
        end
        S_MULT: begin
          r_acc  <= w_acc_nxt;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_load_mul) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: loads on a new result, otherwise holds; valid drops on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load_alu || w_load_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_ld_res;
      r_zero      <= (w_ld_res == '0);
      r_neg       <= w_ld_res[WIDTH-1];
      r_carry     <= w_ld_carry;
      r_ovf       <= w_ld_ovf;
      r_err       <= w_ld_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=16): vector table through a scoreboard queue,
// plus hand-written MUL latency, back-pressure and reset-abort sequences.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         o;
    logic         e;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         o;
    logic         e;
    int           tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         err;

  int   total = 0;
  int   bad   = 0;
  int   tag_n = 0;
  vec_t vt[$];
  exp_t sbq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void add_vec(input logic [3:0] op, input logic [W-1:0] va,
                                  input logic [W-1:0] vb, input logic [W-1:0] r,
                                  input logic z, input logic n, input logic c,
                                  input logic o, input logic e);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = r;
    v.z = z; v.n = n; v.c = c; v.o = o; v.e = e;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Drive one operation; waits (bounded) for acceptance and returns 1ns after the accept edge.
  task automatic send(input vec_t v, input bit push);
    exp_t x;
    bit   done = 0;
    a = v.a; b = v.b; alu_ctrl = v.op; in_valid = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          x.res = v.res; x.z = v.z; x.n = v.n; x.c = v.c; x.o = v.o; x.e = v.e;
          x.tag = tag_n;
          sbq.push_back(x);
        end
        done = 1;
      end
      @(posedge clk); #1;
    end
    tag_n++;
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%h a=%h b=%h", v.op, v.a, v.b);
    end
  endtask

  // Scoreboard: compare each retiring result with the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_spurious: got res=%h with no expected result", result);
      end else begin
        x = sbq.pop_front();
        if ({result, zero, neg, carry, ovf, err} !== {x.res, x.z, x.n, x.c, x.o, x.e}) begin
          bad++;
          $display("FAIL sb_op%0d: got res=%h z%b n%b c%b o%b e%b want res=%h z%b n%b c%b o%b e%b",
                   x.tag, result, zero, neg, carry, ovf, err,
                   x.res, x.z, x.n, x.c, x.o, x.e);
        end
      end
    end
  end

  initial begin
    vec_t v;
    int   lat;
    int   ir_bad;
    int   vcount;

    // op, a, b, result, z, n, c, o, e
    add_vec(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 0);
    add_vec(4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0);
    add_vec(4'b0011, 16'h8001, 16'd4,    16'h0010, 0, 0, 0, 0, 0);
    add_vec(4'b0100, 16'h8001, 16'd16,   16'h0000, 1, 0, 0, 0, 0);
    add_vec(4'b1001, 16'h8001, 16'd3,    16'hF000, 0, 1, 0, 0, 0);
    add_vec(4'b1001, 16'h8001, 16'd40,   16'hFFFF, 0, 1, 0, 0, 0);
    add_vec(4'b0111, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 0, 0);
    add_vec(4'b1010, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 0, 0);
    add_vec(4'b1011, 16'd300,  16'd300,  16'h5F90, 0, 0, 0, 1, 0);
    add_vec(4'b1011, 16'd7,    16'd9,    16'h003F, 0, 0, 0, 0, 0);
    add_vec(4'b1110, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, 1);
    add_vec(4'b0010, 16'h00FF, 16'h0000, 16'hFF00, 0, 1, 0, 0, 0);
    add_vec(4'b0101, 16'hF0F0, 16'hFF00, 16'hF000, 0, 1, 0, 0, 0);
    add_vec(4'b0110, 16'hF0F0, 16'hFF00, 16'hFFF0, 0, 1, 0, 0, 0);
    add_vec(4'b1000, 16'hF0F0, 16'hFF00, 16'h0FF0, 0, 0, 0, 0, 0);
    add_vec(4'b0011, 16'h8001, 16'd0,    16'h8001, 0, 1, 0, 0, 0);
    add_vec(4'b1001, 16'h8001, 16'd0,    16'h8001, 0, 1, 0, 0, 0);
    add_vec(4'b0001, 16'h0001, 16'h0002, 16'hFFFF, 0, 1, 1, 0, 0);
    add_vec(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 0);
    add_vec(4'b1111, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_ctrl = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result), 32'd0);
    check("rst_flags",     32'({zero, neg, carry, ovf, err}), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table vectors, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    foreach (vt[i]) send(vt[i], 1'b1);
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    #1 check("table_drained", 32'(sbq.size()), 32'd0);

    // MUL latency: result exactly WIDTH cycles after accept, in_ready low meanwhile.
    v.op = 4'b1011; v.a = 16'd300; v.b = 16'd300; v.res = 16'h5F90;
    v.z = 0; v.n = 0; v.c = 0; v.o = 1; v.e = 0;
    send(v, 1'b1);
    lat = -1; ir_bad = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) ir_bad++;
    end
    check("mul_latency", 32'(lat), 32'd16);
    check("mul_in_ready_low", 32'(ir_bad), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: first ADD accepted, second held off while result stays put.
    out_ready = 1'b0;
    v.op = 4'b0000; v.a = 16'd1; v.b = 16'd1; v.res = 16'd2;
    v.z = 0; v.n = 0; v.c = 0; v.o = 0; v.e = 0;
    send(v, 1'b1);
    a = 16'd2; b = 16'd2; alu_ctrl = 4'b0000; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_valid, result}), {15'd0, 1'b1, 16'd2});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    v.a = 16'd2; v.b = 16'd2; v.res = 16'd4;
    send(v, 1'b1);
    v.a = 16'd3; v.b = 16'd3; v.res = 16'd6;
    send(v, 1'b1);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    #1 check("bp_drained", 32'(sbq.size()), 32'd0);

    // Reset while the multiplier is at cnt=5: nothing may come out afterwards.
    v.op = 4'b1011; v.a = 16'd300; v.b = 16'd300;
    send(v, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready), 32'd1);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("abort_no_stale", 32'(vcount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
